// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect request and the decode handshake.
// Decode handshake: an entry transfers on a rising edge where inst_valid_o && inst_ready_i;
// while inst_valid_o && !inst_ready_i, inst_valid_o/inst_o/inst_pc_o hold stable.
interface fetch_stage_if;
  logic [31:0] imem_pc_o;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  modport master (
    output imem_pc_o,
    input  imem_data_i,
    input  redirect_i,
    input  redirect_pc_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o,
    output inst_pc_o
  );

  modport slave (
    input  imem_pc_o,
    output imem_data_i,
    output redirect_i,
    output redirect_pc_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o,
    input  inst_pc_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: issues sequential PCs to a synchronous-read memory,
// buffers returned words in a small FIFO and hands (inst, pc) pairs to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic           clk_i,
  input logic           rst_ni,
  fetch_stage_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [31:0]   inst_q;
  logic [31:0]   inst_pc_q;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic          head_from_push;
  logic [CW:0]   occupancy;
  logic [CW-1:0] count_after_pop;
  logic [CW-1:0] count_d;
  logic [PW-1:0] rd_ptr_d;
  logic [31:0]   redirect_target;

  always_comb begin
    pop             = 1'b0;
    push            = 1'b0;
    issue           = 1'b0;
    occupancy       = '0;
    count_after_pop = '0;
    count_d         = '0;
    rd_ptr_d        = '0;
    head_from_push  = 1'b0;
    redirect_target = '0;

    pop  = (count_q != '0) && bus.inst_ready_i;
    push = inflight_q && !bus.redirect_i;
    // Words already buffered plus the one still coming back, less the one leaving now.
    occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue     = !bus.redirect_i && (occupancy < (CW+1)'(FIFO_DEPTH));

    count_after_pop = count_q - CW'(pop);
    count_d         = count_after_pop + CW'(push);
    rd_ptr_d        = rd_ptr_q + PW'(pop);
    // The word being written becomes the head when nothing older remains.
    head_from_push  = push && (count_after_pop == '0);
    redirect_target = bus.redirect_pc_i & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
    end else if (bus.redirect_i) begin
      pc_q       <= redirect_target;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      if (issue) begin
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end else begin
        inflight_q <= 1'b0;
      end

      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end

      // Output registers track the next head; they keep the last value once empty.
      if (count_d != '0) begin
        if (head_from_push) begin
          inst_q    <= bus.imem_data_i;
          inst_pc_q <= inflight_pc_q;
        end else begin
          inst_q    <= fifo_inst[rd_ptr_d];
          inst_pc_q <= fifo_pc[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_inst[wr_ptr_q] <= bus.imem_data_i;
      fifo_pc[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign bus.imem_pc_o    = pc_q;
  assign bus.inst_valid_o = (count_q != '0);
  assign bus.inst_o       = inst_q;
  assign bus.inst_pc_o    = inst_pc_q;

  no_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (count_after_pop == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed latency/stall/redirect/wrap cases plus a random-ready
// phase, with a scoreboard that expects a strictly sequential stream from each restart point.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_1000;
  localparam int          MEM_WORDS = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [MEM_WORDS];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int idx;
    if (a >= 32'h0000_1000 && a < 32'h0000_1000 + 32'(MEM_WORDS * 4)) begin
      idx = int'((a - 32'h0000_1000) >> 2);
      return mem_arr[idx];
    end
    return 32'h0;
  endfunction

  always @(posedge clk) bus.imem_data_i <= mem_word(bus.imem_pc_o);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_inst;
  logic [31:0] prev_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake pops one expected {pc, inst}; a restart replaces the stream.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_ni) begin
      exp_q.delete();
      model_pc  = RESET_PC;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(bus.inst_valid_o), 32'd1);
        check("hold_inst", bus.inst_o, prev_inst);
        check("hold_pc", bus.inst_pc_o, prev_pc);
      end
      if (bus.inst_valid_o === 1'b1 && bus.inst_ready_i === 1'b1) begin
        e = exp_q.pop_front();
        check("sb_pc", bus.inst_pc_o, e[63:32]);
        check("sb_inst", bus.inst_o, e[31:0]);
        n_pop++;
      end
      prev_hold = (bus.inst_valid_o === 1'b1) && !bus.inst_ready_i && !bus.redirect_i;
      prev_inst = bus.inst_o;
      prev_pc   = bus.inst_pc_o;
      if (bus.redirect_i) begin
        exp_q.delete();
        model_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
      end
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back({model_pc, mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] wpc;
    for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = $urandom;
    mem_arr[0] = 32'h0000_0011;
    mem_arr[1] = 32'h0000_0022;
    mem_arr[2] = 32'h0000_0033;

    rst_ni            = 1'b0;
    bus.inst_ready_i  = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    tick(); tick(); tick();

    check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
    check("rst_inst", bus.inst_o, 32'h0);
    check("rst_inst_pc", bus.inst_pc_o, 32'h0);
    check("rst_imem_pc", bus.imem_pc_o, RESET_PC);

    // First words after reset release, ready held high.
    bus.inst_ready_i = 1'b1;
    rst_ni           = 1'b1;
    at_neg(); check("t1_valid_c0", 32'(bus.inst_valid_o), 32'd0);
    tick(); at_neg(); check("t1_valid_c1", 32'(bus.inst_valid_o), 32'd0);
    tick(); at_neg(); check("t1_valid_c2", 32'(bus.inst_valid_o), 32'd1);
    check("t1_pc0", bus.inst_pc_o, 32'h1000); check("t1_inst0", bus.inst_o, 32'h11);
    tick(); at_neg(); check("t1_pc1", bus.inst_pc_o, 32'h1004); check("t1_inst1", bus.inst_o, 32'h22);
    tick(); at_neg(); check("t1_pc2", bus.inst_pc_o, 32'h1008); check("t1_inst2", bus.inst_o, 32'h33);

    // Stall from cycle 2 for 5 cycles.
    tick(); rst_ni = 1'b0;
    tick(); rst_ni = 1'b1; bus.inst_ready_i = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("t2_valid", 32'(bus.inst_valid_o), 32'd1);
      check("t2_pc", bus.inst_pc_o, 32'h1000);
      check("t2_inst", bus.inst_o, 32'h11);
      check("t2_imem_pc", bus.imem_pc_o, 32'h1008);
      tick();
    end
    bus.inst_ready_i = 1'b1;
    repeat (3) tick();

    // Redirect while the FIFO is full; a pop in the same cycle still completes.
    bus.inst_ready_i = 1'b0;
    repeat (4) tick();
    at_neg(); check("t3_full_valid", 32'(bus.inst_valid_o), 32'd1);
    tick();
    bus.inst_ready_i  = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_1043;
    tick(); bus.redirect_i = 1'b0;
    at_neg(); check("t3_gap1", 32'(bus.inst_valid_o), 32'd0);
    tick(); at_neg(); check("t3_gap2", 32'(bus.inst_valid_o), 32'd0);
    tick(); at_neg(); check("t3_valid", 32'(bus.inst_valid_o), 32'd1);
    check("t3_pc", bus.inst_pc_o, 32'h1040); check("t3_inst", bus.inst_o, mem_word(32'h1040));

    // Back-to-back redirects: the second wins.
    tick();
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_1100;
    tick(); bus.redirect_pc_i = 32'h0000_1200;
    tick(); bus.redirect_i = 1'b0;
    at_neg(); check("t4_gap1", 32'(bus.inst_valid_o), 32'd0);
    tick(); at_neg(); check("t4_gap2", 32'(bus.inst_valid_o), 32'd0);
    tick(); at_neg(); check("t4_valid", 32'(bus.inst_valid_o), 32'd1);
    check("t4_pc", bus.inst_pc_o, 32'h1200);

    // Address wrap into unmapped space.
    tick();
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFF8;
    tick(); bus.redirect_i = 1'b0;
    tick(); tick();
    wpc = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check("t5_valid", 32'(bus.inst_valid_o), 32'd1);
      check("t5_pc", bus.inst_pc_o, wpc);
      check("t5_inst", bus.inst_o, 32'h0);
      wpc = wpc + 32'd4;
      tick();
    end

    // Random ready with occasional redirects.
    for (int c = 0; c < 1000; c++) begin
      bus.inst_ready_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        bus.redirect_i = 1'b1;
        if ($urandom_range(0, 3) == 0) bus.redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else bus.redirect_pc_i = 32'h0000_1000 + 32'($urandom_range(0, 4000));
      end else begin
        bus.redirect_i = 1'b0;
      end
      tick();
    end
    bus.redirect_i   = 1'b0;
    bus.inst_ready_i = 1'b1;
    repeat (5) tick();

    // Reset mid-stream takes effect without a clock edge.
    at_neg(); check("t6_pre_reset_valid", 32'(bus.inst_valid_o), 32'd1);
    tick();
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.inst_valid_o), 32'd0);
    check("t6_rst_inst", bus.inst_o, 32'h0);
    check("t6_rst_inst_pc", bus.inst_pc_o, 32'h0);
    check("t6_rst_imem_pc", bus.imem_pc_o, RESET_PC);
    tick(); rst_ni = 1'b1;
    repeat (10) tick();

    check("pop_progress", 32'(n_pop > 300), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end; drives the PC port of the synchronous-read instruction memory and consumes its 32-bit read data one cycle later.
- Tracks the in-flight request and buffers returned words in a small FIFO.
- Presents (instruction, pc) pairs to decode through a valid/ready handshake.
- Handles stalls from decode and PC redirects (branch/jump/trap) by flushing.

Parameters:
- RESET_PC, `MEM_INSTR_ZERO (const.v): first fetch address after reset; must be 4-aligned.
- FIFO_DEPTH, 2: output buffer entries; power of two, >= 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- imem_pc_o  output  32  fetch address to instruction memory; memory samples it on the rising edge.
- imem_data_i  input  32  instruction memory read data; valid in the cycle after the address was sampled.
- redirect_i  input  1  one-cycle pulse: discard all fetched/in-flight words and restart at redirect_pc_i.
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored (forced to 00).
- inst_valid_o  output  1  inst_o/inst_pc_o hold a valid entry.
- inst_ready_i  input  1  decode accepts the entry this cycle.
- inst_o  output  32  instruction word.
- inst_pc_o  output  32  address the instruction was fetched from.

Behaviour:
- State: pc_q (next address to issue), inflight_q and inflight_pc_q (request issued last cycle), FIFO (count_q, rd/wr pointers, entries of {pc, inst}).
- Reset (async assert; synchronous-to-clock deassert is the integrator's job):
  - pc_q = RESET_PC; inflight_q = 0; count_q = 0; pointers = 0.
  - inst_valid_o = 0; inst_o = 0; inst_pc_o = 0; imem_pc_o = RESET_PC.
- imem_pc_o = pc_q combinationally, every cycle. Memory reads unconditionally; only "issued" cycles are tracked.
- pop = inst_valid_o && inst_ready_i.
- issue = !redirect_i && (count_q + inflight_q - pop) < FIFO_DEPTH.
  - On issue: inflight_q <= 1; inflight_pc_q <= pc_q; pc_q <= pc_q + 4, 32-bit wrap, 0xFFFFFFFC -> 0x00000000.
  - Otherwise: inflight_q <= 0; pc_q holds.
- Writeback: when inflight_q && !redirect_i, push {inflight_pc_q, imem_data_i} into the FIFO this edge.
  - The issue rule guarantees there is space; overflow is a design error (assertion).
- Output is registered from the FIFO head, with no bypass:
  - inst_valid_o = (count_q != 0); inst_o/inst_pc_o = head entry.
  - When inst_valid_o = 0, inst_o/inst_pc_o hold the last value (0 after reset).
  - Latency: address issued in cycle t, data on imem_data_i in t+1, head visible in t+2.
  - Steady-state throughput is 1 instruction/cycle with inst_ready_i held high.
- Stall (inst_ready_i = 0):
  - Head and outputs are held stable; valid/data must not change while valid && !ready.
  - Issue continues until count_q + inflight_q = FIFO_DEPTH, then pc_q freezes.
  - No word is ever lost or duplicated.
- Simultaneous push and pop: count_q unchanged, both pointers advance.
- Redirect in cycle t:
  - FIFO cleared (count_q <= 0, pointers reset); inflight_q <= 0, so the word returning in t+1 is dropped.
  - pc_q <= {redirect_pc_i[31:2], 2'b00}; no issue in t.
  - Target issued in t+1, visible on outputs in t+3.
  - A pop occurring in t still completes: decode consumed it, and the flush does not undo that.
  - Redirect has priority over issue, push and pop-driven space accounting.
- Back-to-back redirects: the last one wins; each restarts the sequence above.
- Memory out-of-range reads return 0; the block passes 0 through as an ordinary instruction (decode owns illegal-instruction handling).

Test Plan:
- Reset with RESET_PC = 0x0000_1000 and memory words 0x11,0x22,0x33 at 0x1000/4/8; ready = 1 -> inst_valid_o first high in cycle 2 after reset release; pairs (0x1000,0x11), (0x1004,0x22), (0x1008,0x33) on consecutive cycles.
- Hold ready = 0 from cycle 2 for 5 cycles -> (0x1000,0x11) stable throughout; imem_pc_o freezes at 0x1008; after release, 0x1004 and 0x1008 each delivered exactly once in order.
- Pulse redirect_i with redirect_pc_i = 0x0000_1043 while FIFO is full -> inst_valid_o = 0 for the next 2 cycles; next valid pair is (0x1040, mem[0x1040]); no pre-redirect pc appears.
- Redirect on consecutive cycles to 0x1100 then 0x1200 -> only the 0x1200 stream appears, starting 3 cycles after the second pulse.
- Set pc near wrap via redirect to 0xFFFF_FFF8 -> delivered pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004; out-of-range words are 0x00000000.
- Random ready (50%) over 1000 cycles with a scoreboard -> pcs strictly sequential by 4 (mod 2^32); valid never drops without a pop; assert reset mid-stream -> outputs return to reset values immediately.
